// File: rtl/obi_wrr_sched_pkg.sv
// rtl/obi_wrr_sched_pkg.sv - shared types, defaults and index-width helper for obi_wrr_sched
package obi_wrr_sched_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } obi_wrr_state_e;

   localparam int unsigned DefaultMaxTransPerPort = 2;

   // Width needed to encode an index into num_idx entries (at least one bit).
   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction

endpackage

// File: rtl/obi_wrr_sched_fifo.sv
// rtl/obi_wrr_sched_fifo.sv - registered-output index FIFO with synchronous flush
module obi_wrr_sched_fifo #(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AddrW-1:0]      r_wr_ptr;
   logic [AddrW-1:0]      r_rd_ptr;
   logic [CntW-1:0]       r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign full_o    = (r_count == CntW'(DEPTH));
   assign empty_o   = (r_count == '0);
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && !empty_o;
   assign data_o    = r_mem[r_rd_ptr];

   function automatic logic [AddrW-1:0] ptr_next(input logic [AddrW-1:0] ptr);
      return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + AddrW'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
            r_wr_ptr        <= ptr_next(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= ptr_next(r_rd_ptr);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CntW'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CntW'(1);
         end
      end
   end

endmodule

// File: rtl/obi_wrr_sched.sv
// rtl/obi_wrr_sched.sv - weighted round-robin N:1 OBI scheduler with per-port and total
// in-flight caps; granted indices are queued so in-order R beats route back to their port.
module obi_wrr_sched
   import obi_wrr_sched_pkg::*;
#(
   parameter int unsigned NumSbrPorts     = 4,
   parameter int unsigned NumMaxTrans     = 4,
   parameter int unsigned MaxTransPerPort = DefaultMaxTransPerPort,
   parameter int unsigned WeightWidth     = 2,
   parameter bit          UseRReady       = 1'b0,
   localparam int unsigned IdxWidth       = idx_width(NumSbrPorts)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumSbrPorts-1:0]             sbr_req_i,
   output logic [NumSbrPorts-1:0]             sbr_gnt_o,
   input  logic [NumSbrPorts*WeightWidth-1:0] weight_i,
   output logic                               mgr_req_o,
   input  logic                               mgr_gnt_i,
   output logic [IdxWidth-1:0]                sel_idx_o,
   input  logic                               mgr_rvalid_i,
   input  logic                               mgr_rready_i,
   output logic [IdxWidth-1:0]                rsp_idx_o,
   output logic                               busy_o,
   output logic                               rsp_err_o
);

   if (NumSbrPorts < 2) begin : g_bad_ports
      $fatal(1, "obi_wrr_sched: NumSbrPorts must be >= 2");
   end
   if (NumMaxTrans < 1 || MaxTransPerPort < 1 || MaxTransPerPort > NumMaxTrans) begin : g_bad_trans
      $fatal(1, "obi_wrr_sched: illegal transaction limits");
   end

   localparam int unsigned CntWidth = $clog2(MaxTransPerPort + 1);

   obi_wrr_state_e         r_state;
   obi_wrr_state_e         w_state_next;
   logic [IdxWidth-1:0]    r_ptr;
   logic [IdxWidth-1:0]    r_hold_idx;
   logic [WeightWidth-1:0] r_credit;
   logic [CntWidth-1:0]    r_cnt [NumSbrPorts];
   logic [WeightWidth-1:0] w_weight [NumSbrPorts];
   logic [NumSbrPorts-1:0] w_eligible;
   logic [NumSbrPorts-1:0] w_gnt;
   logic [IdxWidth-1:0]    w_scan_idx;
   logic [IdxWidth-1:0]    w_sel;
   logic [IdxWidth-1:0]    w_head;
   logic                   w_scan_found;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic                   w_req;
   logic                   w_accept;
   logic                   w_retire;
   logic                   w_pop;

   for (genvar i = 0; i < NumSbrPorts; i++) begin : g_port
      assign w_weight[i]   = weight_i[i*WeightWidth +: WeightWidth];
      assign w_eligible[i] = sbr_req_i[i] && (r_cnt[i] < CntWidth'(MaxTransPerPort)) && !w_fifo_full;

      // A same-cycle push and pop of this port leave the count untouched.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            r_cnt[i] <= '0;
         end else begin
            if ((w_accept && w_sel == IdxWidth'(i)) && !(w_pop && w_head == IdxWidth'(i))) begin
               r_cnt[i] <= r_cnt[i] + CntWidth'(1);
            end else if ((w_pop && w_head == IdxWidth'(i)) && !(w_accept && w_sel == IdxWidth'(i))) begin
               r_cnt[i] <= r_cnt[i] - CntWidth'(1);
            end
         end
      end
   end

   // Round-robin scan beginning one past the pointer, wrapping back to the pointer last.
   always_comb begin
      w_scan_idx   = r_ptr;
      w_scan_found = 1'b0;
      for (int k = 1; k <= int'(NumSbrPorts); k++) begin
         int unsigned idx;
         idx = (int'(r_ptr) + k) % NumSbrPorts;
         if (!w_scan_found && w_eligible[idx]) begin
            w_scan_idx   = IdxWidth'(idx);
            w_scan_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sel        = w_scan_idx;
      w_req        = 1'b0;
      case (r_state)
         ARB: begin
            if (w_eligible[r_ptr] && r_credit != '0) begin
               w_sel = r_ptr;
            end
            w_req = rst_ni && (|w_eligible);
            if (w_req && !mgr_gnt_i) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            w_sel = r_hold_idx;
            w_req = rst_ni;
            if (mgr_gnt_i) begin
               w_state_next = ARB;
            end
         end
         default: w_state_next = ARB;
      endcase
   end

   assign w_accept = w_req && mgr_gnt_i;
   assign w_retire = rst_ni && mgr_rvalid_i && (mgr_rready_i || !UseRReady);
   assign w_pop    = w_retire && !w_fifo_empty;

   always_comb begin
      w_gnt = '0;
      if (w_accept) begin
         w_gnt[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= ARB;
         r_ptr      <= '0;
         r_credit   <= '0;
         r_hold_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ARB) begin
            r_hold_idx <= w_sel;
         end
         if (w_accept) begin
            if (w_sel == r_ptr && r_credit != '0) begin
               r_credit <= r_credit - WeightWidth'(1);
            end else begin
               r_ptr    <= w_sel;
               r_credit <= w_weight[w_sel];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && r_state == HOLD) begin
         assert (sbr_req_i[r_hold_idx]);
      end
   end

   obi_wrr_sched_fifo #(
      .DATA_WIDTH (IdxWidth),
      .DEPTH      (NumMaxTrans)
   ) u_idx_fifo (
      .clk_i   (clk_i),
      .flush_i (!rst_ni),
      .push_i  (w_accept),
      .data_i  (w_sel),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   assign sbr_gnt_o = w_gnt;
   assign mgr_req_o = w_req;
   assign sel_idx_o = rst_ni ? w_sel : '0;
   assign rsp_idx_o = (rst_ni && !w_fifo_empty) ? w_head : '0;
   assign busy_o    = rst_ni && !w_fifo_empty;
   assign rsp_err_o = w_retire && w_fifo_empty;

endmodule

// File: tb/tb_obi_wrr_sched.sv
// tb/tb_obi_wrr_sched.sv - directed scoreboard bench for obi_wrr_sched (N=4, depth 4, 2 per port)
module tb_obi_wrr_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sbr_req;
   logic [3:0] sbr_gnt;
   logic [7:0] weight;
   logic       mgr_req;
   logic       mgr_gnt;
   logic [1:0] sel_idx;
   logic       mgr_rvalid;
   logic       mgr_rready;
   logic [1:0] rsp_idx;
   logic       busy;
   logic       rsp_err;

   int n_checks = 0;
   int n_fail   = 0;
   int q_gnt[$];
   int q_rsp[$];

   always #5 clk = ~clk;

   obi_wrr_sched dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .sbr_req_i    (sbr_req),
      .sbr_gnt_o    (sbr_gnt),
      .weight_i     (weight),
      .mgr_req_o    (mgr_req),
      .mgr_gnt_i    (mgr_gnt),
      .sel_idx_o    (sel_idx),
      .mgr_rvalid_i (mgr_rvalid),
      .mgr_rready_i (mgr_rready),
      .rsp_idx_o    (rsp_idx),
      .busy_o       (busy),
      .rsp_err_o    (rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Settle, score this cycle's accept / retire against the queues, then advance one clock.
   task automatic cycle();
      int e;
      logic [31:0] one;
      #1;
      one = 32'd1;
      if (mgr_req && mgr_gnt) begin
         if (q_gnt.size() == 0) begin
            chk("unexpected_accept", 32'd1, 32'd0);
         end else begin
            e = q_gnt.pop_front();
            chk("grant_sel", 32'(sel_idx), 32'(e));
            chk("grant_onehot", 32'(sbr_gnt), one << e);
         end
      end else begin
         chk("gnt_idle", 32'(sbr_gnt), 32'd0);
      end
      if (mgr_rvalid && rst_n) begin
         if (q_rsp.size() == 0) begin
            chk("rsp_err_empty", 32'(rsp_err), 32'd1);
         end else begin
            e = q_rsp.pop_front();
            chk("rsp_idx", 32'(rsp_idx), 32'(e));
            chk("rsp_err_low", 32'(rsp_err), 32'd0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      sbr_req    = '0;
      mgr_gnt    = 1'b1;
      mgr_rvalid = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   // Reset, then one grant+retire on port 3 so the pointer sits on 3 with no credit.
   task automatic prime();
      do_reset();
      weight  = '0;
      sbr_req = 4'b1000;
      q_gnt.push_back(3);
      q_rsp.push_back(3);
      cycle();
      sbr_req    = '0;
      mgr_rvalid = 1'b1;
      cycle();
      mgr_rvalid = 1'b0;
   endtask

   initial begin
      mgr_rready = 1'b0;
      weight     = '0;
      do_reset();
      #1;
      chk("reset_req", 32'(mgr_req), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rsp_idx", 32'(rsp_idx), 32'd0);
      chk("reset_sel_idx", 32'(sel_idx), 32'd0);

      // 1: equal weights, plain round robin
      prime();
      sbr_req = 4'b1111;
      foreach (q_gnt[i]) q_gnt.delete(i);
      q_gnt = '{0, 1, 2, 3, 0};
      q_rsp = '{0, 1, 2, 3, 0};
      cycle();
      mgr_rvalid = 1'b1;
      repeat (4) cycle();
      sbr_req = '0;
      cycle();
      mgr_rvalid = 1'b0;
      chk("t1_drained", 32'(q_gnt.size() + q_rsp.size()), 32'd0);

      // 2: port 1 weight 2 gets three consecutive grants
      prime();
      weight  = 8'b0000_1000;
      sbr_req = 4'b1111;
      q_gnt   = '{0, 1, 1, 1, 2, 3, 0};
      q_rsp   = '{0, 1, 1, 1, 2, 3, 0};
      cycle();
      mgr_rvalid = 1'b1;
      repeat (6) cycle();
      sbr_req = '0;
      cycle();
      mgr_rvalid = 1'b0;
      weight     = '0;
      chk("t2_drained", 32'(q_gnt.size() + q_rsp.size()), 32'd0);

      // 3: per-port cap
      do_reset();
      sbr_req = 4'b0100;
      q_gnt   = '{2, 2};
      cycle();
      cycle();
      chk("t3_cap_req_low", 32'(mgr_req), 32'd0);
      cycle();
      chk("t3_cap_req_still_low", 32'(mgr_req), 32'd0);
      mgr_rvalid = 1'b1;
      #1;
      chk("t3_no_comb_req", 32'(mgr_req), 32'd0);
      q_rsp.push_back(2);
      cycle();
      mgr_rvalid = 1'b0;
      #1;
      chk("t3_req_resume", 32'(mgr_req), 32'd1);
      q_gnt.push_back(2);
      cycle();
      sbr_req = '0;
      q_rsp.push_back(2);
      q_rsp.push_back(2);
      mgr_rvalid = 1'b1;
      repeat (2) cycle();
      mgr_rvalid = 1'b0;
      chk("t3_idle_busy", 32'(busy), 32'd0);
      chk("t3_drained", 32'(q_gnt.size() + q_rsp.size()), 32'd0);

      // 4: request held stable through gnt-low cycles
      prime();
      mgr_gnt = 1'b0;
      sbr_req = 4'b1000;
      cycle();
      sbr_req = 4'b1001;
      cycle();
      chk("t4_hold_sel_a", 32'(sel_idx), 32'd3);
      chk("t4_hold_req", 32'(mgr_req), 32'd1);
      cycle();
      chk("t4_hold_sel_b", 32'(sel_idx), 32'd3);
      mgr_gnt = 1'b1;
      q_gnt   = '{3, 0};
      q_rsp   = '{3, 0};
      cycle();
      cycle();
      sbr_req    = '0;
      mgr_rvalid = 1'b1;
      repeat (2) cycle();
      mgr_rvalid = 1'b0;
      chk("t4_drained", 32'(q_gnt.size() + q_rsp.size()), 32'd0);

      // 5: total cap, full-FIFO bubble, in-order response routing
      prime();
      sbr_req = 4'b1111;
      q_gnt   = '{0, 1, 2, 3};
      q_rsp   = '{0, 1, 2, 3};
      repeat (4) cycle();
      chk("t5_full_req_low", 32'(mgr_req), 32'd0);
      chk("t5_full_busy", 32'(busy), 32'd1);
      mgr_rvalid = 1'b1;
      #1;
      chk("t5_full_pop_bubble", 32'(mgr_req), 32'd0);
      cycle();
      sbr_req = '0;
      repeat (3) cycle();
      mgr_rvalid = 1'b0;
      chk("t5_idle_busy", 32'(busy), 32'd0);
      chk("t5_drained", 32'(q_gnt.size() + q_rsp.size()), 32'd0);

      // 6: retire on empty FIFO, then reset while holding
      do_reset();
      mgr_rvalid = 1'b1;
      cycle();
      mgr_rvalid = 1'b0;
      #1;
      chk("t6_err_one_cycle", 32'(rsp_err), 32'd0);
      sbr_req = 4'b0100;
      q_gnt   = '{2, 2};
      repeat (2) cycle();
      sbr_req = 4'b0001;
      mgr_gnt = 1'b0;
      cycle();
      chk("t6_hold_req", 32'(mgr_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req", 32'(mgr_req), 32'd0);
      chk("t6_rst_outs", {26'd0, sbr_gnt, busy, rsp_err}, 32'd0);
      chk("t6_rst_idx", {28'd0, sel_idx, rsp_idx}, 32'd0);
      cycle();
      chk("t6_rst_req_after_edge", 32'(mgr_req), 32'd0);
      chk("t6_rst_busy_after_edge", 32'(busy), 32'd0);
      rst_n   = 1'b1;
      sbr_req = '0;
      #1;
      chk("t6_flushed_req", 32'(mgr_req), 32'd0);
      chk("t6_flushed_busy", 32'(busy), 32'd0);
      sbr_req = 4'b0001;
      mgr_gnt = 1'b1;
      q_gnt.push_back(0);
      cycle();
      sbr_req = '0;
      q_rsp.push_back(0);
      mgr_rvalid = 1'b1;
      cycle();
      mgr_rvalid = 1'b0;
      chk("t6_drained", 32'(q_gnt.size() + q_rsp.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
